// File: rtl/regdump_pkg.sv
// regdump_pkg: shared types and default sizing for the register-file dump block.
// Contents: dump FSM state enum, default NREGS/XLEN/AW constants.
package regdump_pkg;

    localparam int unsigned DEF_NREGS = 32;
    localparam int unsigned DEF_XLEN  = 32;
    localparam int unsigned DEF_AW    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_CSUM,
        ST_DONE
    } state_e;

endpackage

// File: rtl/regdump_csum.sv
// regdump_csum: XOR accumulator folding in every captured register word.
// Ports: clk, rst_n (async, active low); clr (sync clear, wins over en);
//        en folds din into acc; acc is the running XOR.
module regdump_csum
    import regdump_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/regfile.sv
// regfile: register file with one write port and two combinational read ports.
// x0 always reads as zero and ignores writes.
// Ports: clk; we/waddr/wdata write port; rs1/rd1 and rs2/rd2 read ports.
module regfile
    import regdump_pkg::*;
#(
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned XLEN  = DEF_XLEN,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] mem [NREGS];

    // Storage is not reset; architectural state is defined by software writes.
    always_ff @(posedge clk) begin
        if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd1 = (rs1 == '0) ? '0 : mem[rs1];
    assign rd2 = (rs2 == '0) ? '0 : mem[rs2];

endmodule

// File: rtl/regfile_dump.sv
// regfile_dump: on start, walks the regfile rs2 port from x0 to x(NREGS-1) and
// streams each value over valid/ready with its index attached.
// Optional feature: define REGDUMP_CHECKSUM_EN to append an XOR checksum word
// (out_sum=1, out_idx=0) after the last register.
// Ports: clk, rst_n (async, active low); start; busy; done (1-cycle pulse);
//        rf_rs/rf_rdata regfile read port; out_valid/out_ready handshake;
//        out_data, out_idx, out_last, out_sum word payload.
module regfile_dump
    import regdump_pkg::*;
#(
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned XLEN  = DEF_XLEN,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   rf_rs,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [AW-1:0]   out_idx,
    output logic            out_last,
    output logic            out_sum
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] data_d;
    logic [AW-1:0]   oidx_d;
    logic            busy_d, done_d, valid_d, last_d;

`ifdef REGDUMP_CHECKSUM_EN
    logic [XLEN-1:0] acc;
    logic            sum_d;

    regdump_csum #(.XLEN(XLEN)) u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state_q == ST_IDLE) && start),
        .en    (state_q == ST_FETCH),
        .din   (rf_rdata),
        .acc   (acc)
    );
`endif

    // Next state, next index and next registered outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = out_data;
        oidx_d  = out_idx;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                data_d  = rf_rdata;
                oidx_d  = idx_q;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
                        // acc already holds the last word, folded at its FETCH.
                        data_d  = acc;
                        oidx_d  = '0;
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_CSUM: begin
                if (out_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        valid_d = (state_d == ST_SEND) || (state_d == ST_CSUM);
`ifdef REGDUMP_CHECKSUM_EN
        last_d  = (state_d == ST_CSUM);
        sum_d   = (state_d == ST_CSUM);
`else
        last_d  = (state_d == ST_SEND) && (idx_d == LAST_IDX);
`endif
    end

    // State, index and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy      <= busy_d;
            done      <= done_d;
            out_valid <= valid_d;
            out_data  <= data_d;
            out_idx   <= oidx_d;
            out_last  <= last_d;
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum <= 1'b0;
        end else begin
            out_sum <= sum_d;
        end
    end
`else
    assign out_sum = 1'b0;
`endif

    // The read address is the index register itself.
    assign rf_rs = idx_q;

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed bench for regfile_dump driving a real regfile.
// Covers reset state, latency, full in-order dump, backpressure, ignored
// restart, reset abort and restart. Honours REGDUMP_CHECKSUM_EN if defined.
module tb_regfile_dump;

    localparam int unsigned AW   = 5;
    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            busy, done;
    logic [AW-1:0]   rf_rs;
    logic [XLEN-1:0] rf_rdata;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_data;
    logic [AW-1:0]   out_idx;
    logic            out_last, out_sum;

    logic            we = 1'b0;
    logic [AW-1:0]   waddr = '0;
    logic [XLEN-1:0] wdata = '0;
    logic [XLEN-1:0] rd1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile u_rf (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .rs1   ('0),
        .rs2   (rf_rs),
        .rd1   (rd1),
        .rd2   (rf_rdata)
    );

    regfile_dump u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rf_rs     (rf_rs),
        .rf_rdata  (rf_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_sum   (out_sum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input logic [31:0] v);
        we    = 1'b1;
        waddr = AW'(k);
        wdata = v;
        tick();
        we    = 1'b0;
    endtask

    // Advance (ready high) until the word with index idx is on the bus.
    task automatic wait_send(input int idx);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (out_valid && (out_idx == AW'(idx))) found = 1'b1;
            else tick();
        end
        chk($sformatf("reach_idx%0d", idx), 32'(found), 32'd1);
    endtask

    // Run to completion counting done pulses within a cycle budget.
    task automatic run_to_done(input string tag);
        int n_done = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done) n_done++;
        end
        chk({tag, "_done_count"}, 32'(n_done), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_rs"},    32'(rf_rs),     32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"},  out_data,       32'd0);
        chk({tag, "_idx"},   32'(out_idx),   32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
        chk({tag, "_sum"},   32'(out_sum),   32'd0);
    endtask

    initial begin
        logic [31:0] acc;
        bit          csum_mode;
`ifdef REGDUMP_CHECKSUM_EN
        csum_mode = 1'b1;
`else
        csum_mode = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #2;
        chk_all_zero("reset");

        // Preload xk = k while the dump block is held in reset.
        for (int k = 1; k < 32; k++) wr(k, 32'(k));
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Full dump with ready held high; start accepted at this edge (cycle 0).
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_busy_c1",  32'(busy),      32'd1);
        chk("lat_valid_c1", 32'(out_valid), 32'd0);
        tick();
        acc = '0;
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("w%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("w%0d_idx", k),   32'(out_idx),   32'(k));
            chk($sformatf("w%0d_data", k),  out_data,       32'(k));
            chk($sformatf("w%0d_last", k),  32'(out_last),
                32'((k == 31) && !csum_mode));
            chk($sformatf("w%0d_done", k),  32'(done),      32'd0);
            acc ^= 32'(k);
            tick();
            if (k < 31) begin
                chk($sformatf("w%0d_gap", k), 32'(out_valid), 32'd0);
                tick();
            end
        end
        if (csum_mode) begin
            chk("csum_valid", 32'(out_valid), 32'd1);
            chk("csum_sum",   32'(out_sum),   32'd1);
            chk("csum_last",  32'(out_last),  32'd1);
            chk("csum_idx",   32'(out_idx),   32'd0);
            chk("csum_data",  out_data,       acc);
            tick();
        end
        chk("done_pulse",   32'(done),      32'd1);
        chk("done_busy",    32'(busy),      32'd1);
        chk("done_valid",   32'(out_valid), 32'd0);
        tick();
        chk("post_done",    32'(done),      32'd0);
        chk("post_busy",    32'(busy),      32'd0);

        // Backpressure at x5, then a start re-pulse at x10 that must be ignored.
        wr(5, 32'h5555_5555);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_send(5);
        chk("bp_data0", out_data, 32'h5555_5555);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_data%0d", i),  out_data,       32'h5555_5555);
            chk($sformatf("bp_idx%0d", i),   32'(out_idx),   32'd5);
        end
        out_ready = 1'b1;
        tick();
        tick();
        chk("bp_next_idx",  32'(out_idx), 32'd6);
        chk("bp_next_data", out_data,     32'd6);
        wait_send(10);
        chk("rs_idx10_data", out_data, 32'd10);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_busy", 32'(busy), 32'd1);
        run_to_done("restart_ignored");

        // Reset while presenting x10 aborts the dump with no done pulse.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_send(10);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        tick();
        tick();
        chk("abort_done_held", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_idle",    32'(busy), 32'd0);

        // A fresh start walks again from x0.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("re_busy", 32'(busy), 32'd1);
        tick();
        chk("re_w0_valid", 32'(out_valid), 32'd1);
        chk("re_w0_idx",   32'(out_idx),   32'd0);
        chk("re_w0_data",  out_data,       32'd0);
        tick();
        tick();
        chk("re_w1_idx",   32'(out_idx),   32'd1);
        chk("re_w1_data",  out_data,       32'd1);
        run_to_done("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
